// File: rtl/wb_queue_pkg.sv
// Shared processor definitions used by the write-back queue:
// participation (PPP) encodings, byte-mask constants and the default queue depth.
package wb_queue_pkg;

  localparam int DEPTH_DEFAULT = 4;

  // Participation field encodings of a retiring instruction
  localparam logic [2:0] PPP_ALL  = 3'b000;  // all eight bytes
  localparam logic [2:0] PPP_LO   = 3'b001;  // bytes 0-3
  localparam logic [2:0] PPP_HI   = 3'b010;  // bytes 4-7
  localparam logic [2:0] PPP_EVEN = 3'b011;  // bytes 0,2,4,6
  localparam logic [2:0] PPP_ODD  = 3'b100;  // bytes 1,3,5,7

  // Byte masks are [0:7]: bit i covers data bits 8i..8i+7 (big-endian numbering)
  localparam logic [0:7] BMASK_FULL = 8'hFF;
  localparam logic [0:7] BMASK_NONE = 8'h00;

  // One queued register-file write
  typedef struct packed {
    logic [4:0]  rd;
    logic [0:63] data;
    logic [0:7]  bmask;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue_ppp_bmask_dec.sv
// Combinational decode of the participation field into a byte write mask.
// Reserved encodings (101-111) yield an empty mask, which the queue discards.
module ppp_bmask_dec
  import wb_queue_pkg::*;
(
  input  logic [2:0] ppp,
  output logic [0:7] bmask
);

  // Map each PPP encoding to the bytes it writes
  always_comb begin
    bmask = BMASK_NONE;
    case (ppp)
      PPP_ALL:  bmask = BMASK_FULL;
      PPP_LO:   bmask = 8'b1111_0000;
      PPP_HI:   bmask = 8'b0000_1111;
      PPP_EVEN: bmask = 8'b1010_1010;
      PPP_ODD:  bmask = 8'b0101_0101;
      default:  bmask = BMASK_NONE;
    endcase
  end

endmodule

// File: rtl/wb_queue.sv
// Write-back queue between the ALU and the register-file write port.
// Buffers ALU results in arrival order, drains one per cycle when the write
// port is free, forwards the youngest full-width pending value of a register
// and raises stall when nearly full. Results that arrive while the queue is
// full and not draining are dropped and flagged in a sticky error bit.
module wb_queue
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  parameter int AFULL = DEPTH - 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_v,
  input  logic [0:63] in_data,
  input  logic [4:0]  in_rD,
  input  logic [2:0]  in_ppp,
  input  logic        rf_ready,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [0:63] rf_data,
  output logic [0:7]  rf_bmask,
  input  logic [4:0]  fwd_addr,
  output logic        fwd_hit,
  output logic [0:63] fwd_data,
  output logic        stall,
  output logic        ovf_err
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL);

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             ovf_reg;

  // Payload storage; validity is tracked by pointers/count only, so no reset
  wb_entry_t mem [DEPTH];

  logic [0:7] in_bmask;
  logic       empty;
  logic       full;
  logic       pop;
  logic       push;
  logic       drop;
  wb_entry_t  head;

  ppp_bmask_dec u_dec (
    .ppp   (in_ppp),
    .bmask (in_bmask)
  );

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_CNT);
  assign pop   = !empty && rf_ready;
  // A full queue still accepts a result when the head leaves in the same cycle
  assign push  = in_v && (in_bmask != BMASK_NONE) && (!full || pop);
  assign drop  = in_v && (in_bmask != BMASK_NONE) && full && !pop;

  // Pointer, occupancy and sticky overflow bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      if (drop) ovf_reg <= 1'b1;
    end
  end

  // Capture the incoming result at the tail slot
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= '{rd: in_rD, data: in_data, bmask: in_bmask};
  end

  assign head     = mem[rd_ptr_reg];
  assign rf_we    = pop;
  assign rf_addr  = empty ? '0 : head.rd;
  assign rf_data  = empty ? '0 : head.data;
  assign rf_bmask = empty ? '0 : head.bmask;
  assign stall    = (count_reg >= AFULL_CNT);
  assign ovf_err  = ovf_reg;

  // Per physical slot: is it occupied, and does it target the queried register
  logic [DEPTH-1:0] slot_match;
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PTR_W-1:0] slot_age;
      assign slot_age       = PTR_W'(gi) - rd_ptr_reg;
      assign slot_match[gi] = ({1'b0, slot_age} < count_reg) && (mem[gi].rd == fwd_addr);
    end
  endgenerate

  logic [PTR_W-1:0] scan_idx;
  logic             found;
  logic             found_full;
  logic [0:63]      found_data;

  // Walk oldest to youngest so the last match is the youngest; a younger
  // partial write to the same register therefore masks an older full one
  always_comb begin
    scan_idx   = '0;
    found      = 1'b0;
    found_full = 1'b0;
    found_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr_reg + PTR_W'(i);
      if (slot_match[scan_idx]) begin
        found      = 1'b1;
        found_full = (mem[scan_idx].bmask == BMASK_FULL);
        found_data = mem[scan_idx].data;
      end
    end
  end

  assign fwd_hit  = found && found_full;
  assign fwd_data = fwd_hit ? found_data : '0;

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue (DEPTH=4, AFULL=3) using a scoreboard
// of expected register-file writes.
module tb_wb_queue;
  import wb_queue_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_v;
  logic [0:63] in_data;
  logic [4:0]  in_rD;
  logic [2:0]  in_ppp;
  logic        rf_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [0:63] rf_data;
  logic [0:7]  rf_bmask;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [0:63] fwd_data;
  logic        stall;
  logic        ovf_err;

  wb_queue dut (
    .clk      (clk),
    .reset    (reset),
    .in_v     (in_v),
    .in_data  (in_data),
    .in_rD    (in_rD),
    .in_ppp   (in_ppp),
    .rf_ready (rf_ready),
    .rf_we    (rf_we),
    .rf_addr  (rf_addr),
    .rf_data  (rf_data),
    .rf_bmask (rf_bmask),
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data),
    .stall    (stall),
    .ovf_err  (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic [7:0]  mask;
  } exp_t;

  exp_t sb[$];
  bit   model_ovf;
  int   n_cmp;
  int   n_mis;
  int   n_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent PPP decode; value printed MSB-first = byte 0 first
  function automatic logic [7:0] ppp2mask(input logic [2:0] p);
    case (p)
      3'b000:  return 8'hFF;
      3'b001:  return 8'hF0;
      3'b010:  return 8'h0F;
      3'b011:  return 8'hAA;
      3'b100:  return 8'h55;
      default: return 8'h00;
    endcase
  endfunction

  // Drive one cycle of stimulus, check outputs mid-cycle, update the model at the edge
  task automatic cycle(input bit v, input logic [4:0] rd, input logic [63:0] d,
                       input logic [2:0] p, input bit rdy, input logic [4:0] fa);
    bit          exp_we;
    bit          will_push;
    bit          will_drop;
    bit          exp_hit;
    logic [63:0] exp_fd;
    logic [7:0]  m;
    in_v = v; in_rD = rd; in_data = d; in_ppp = p; rf_ready = rdy; fwd_addr = fa;
    @(negedge clk);
    exp_we = (sb.size() != 0) && rdy;
    check("rf_we", rf_we, exp_we);
    if (sb.size() != 0) begin
      check("rf_addr", rf_addr, sb[0].rd);
      check("rf_data", rf_data, sb[0].data);
      check("rf_bmask", rf_bmask, sb[0].mask);
    end else begin
      check("rf_addr_empty", rf_addr, 0);
      check("rf_data_empty", rf_data, 0);
      check("rf_bmask_empty", rf_bmask, 0);
    end
    check("stall", stall, sb.size() >= 3);
    check("ovf_err", ovf_err, model_ovf);
    exp_hit = 1'b0;
    exp_fd  = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].rd == fa) begin
        if (sb[i].mask == 8'hFF) begin
          exp_hit = 1'b1;
          exp_fd  = sb[i].data;
        end
        break;
      end
    end
    check("fwd_hit", fwd_hit, exp_hit);
    check("fwd_data", fwd_data, exp_fd);
    m = ppp2mask(p);
    will_push = v && (m != 0) && ((sb.size() < 4) || exp_we);
    will_drop = v && (m != 0) && (sb.size() == 4) && !exp_we;
    $display("cyc %0d: v=%0b rd=%0d ppp=%0d rdy=%0b -> we=%0b addr=%0d bmask=%h stall=%0b ovf=%0b fwd=%0b occ=%0d",
             n_cyc, v, rd, p, rdy, rf_we, rf_addr, rf_bmask, stall, ovf_err, fwd_hit, sb.size());
    n_cyc++;
    @(posedge clk);
    if (exp_we) void'(sb.pop_front());
    if (will_push) sb.push_back('{rd: rd, data: d, mask: m});
    if (will_drop) model_ovf = 1'b1;
    #1;
  endtask

  // Assert reset mid-cycle; outputs must clear without any clock edge
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_rf_we", rf_we, 0);
    check("rst_stall", stall, 0);
    check("rst_fwd_hit", fwd_hit, 0);
    check("rst_rf_addr", rf_addr, 0);
    check("rst_ovf", ovf_err, 0);
    sb.delete();
    model_ovf = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 64'd0, 3'b000, rdy, 5'd31);
  endtask

  initial begin
    n_cmp = 0; n_mis = 0; n_cyc = 0; model_ovf = 1'b0;
    reset = 1'b1; in_v = 1'b1; in_rD = 5'd9; in_data = 64'hDEAD_BEEF_0000_0001;
    in_ppp = 3'b000; rf_ready = 1'b1; fwd_addr = 5'd9;
    #1;
    check("init_rf_we", rf_we, 0);
    check("init_stall", stall, 0);
    check("init_ovf", ovf_err, 0);
    check("init_fwd_hit", fwd_hit, 0);
    check("init_rf_data", rf_data, 0);
    // in_v held high across the first edge under reset must be ignored
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1, 1'b1);

    // Single full-width result drains one cycle later
    cycle(1'b1, 5'd5, 64'h0123456789ABCDEF, 3'b000, 1'b1, 5'd5);
    idle(2, 1'b1);

    // Fill with the port busy: stall at 3, fifth dropped, then in-order drain
    for (int i = 1; i <= 5; i++)
      cycle(1'b1, 5'(i), {32'hA5A5_0000, 32'(i)}, 3'b000, 1'b0, 5'(i));
    idle(5, 1'b1);

    // Full queue with a simultaneous pop accepts the new result
    do_reset();
    for (int i = 10; i <= 13; i++)
      cycle(1'b1, 5'(i), {32'h1111_0000, 32'(i)}, 3'b000, 1'b0, 5'd13);
    cycle(1'b1, 5'd14, 64'h2222_3333_4444_0014, 3'b000, 1'b1, 5'd14);
    idle(1, 1'b0);
    idle(5, 1'b1);

    // Forwarding: younger partial hides older full; newest full wins
    cycle(1'b1, 5'd7, 64'hAAAA_AAAA_AAAA_AAAA, 3'b000, 1'b0, 5'd7);
    cycle(1'b1, 5'd7, 64'hBBBB_BBBB_BBBB_BBBB, 3'b001, 1'b0, 5'd7);
    cycle(1'b1, 5'd7, 64'hCCCC_CCCC_CCCC_CCCC, 3'b000, 1'b0, 5'd7);
    idle(1, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 5'd0, 64'd0, 3'b000, 1'b1, 5'd7);

    // Even-byte mask and a reserved encoding that must not push
    cycle(1'b1, 5'd3, 64'h0011_2233_4455_6677, 3'b011, 1'b1, 5'd3);
    cycle(1'b1, 5'd4, 64'h8899_AABB_CCDD_EEFF, 3'b110, 1'b1, 5'd4);
    idle(2, 1'b1);

    // Reset in the middle of a drain with three entries queued
    for (int i = 20; i <= 22; i++)
      cycle(1'b1, 5'(i), {32'h3333_0000, 32'(i)}, 3'b010, 1'b0, 5'd20);
    in_v = 1'b0;
    rf_ready = 1'b1;
    #1;
    check("pre_rst_rf_we", rf_we, 1);
    check("pre_rst_stall", stall, 1);
    do_reset();
    idle(3, 1'b1);

    // Randomised traffic with a small register set to exercise forwarding
    for (int i = 0; i < 40; i++)
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), {$urandom, $urandom},
            3'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
    idle(6, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of result entries (power of two, minimum 2).
REQ-002 SHALL have parameter AFULL, default DEPTH-1, meaning occupancy at or above which stall asserts.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_v  input  1  ALU result valid (driven by ALU out_v).
REQ-006 SHALL have port in_data  input  64 [0:63]  ALU result (alu_out).
REQ-007 SHALL have port in_rD  input  5  destination register (rD_out).
REQ-008 SHALL have port in_ppp  input  3  participation field of the retiring instruction.
REQ-009 SHALL have port rf_ready  input  1  register-file write port free this cycle.
REQ-010 SHALL have port rf_we  output  1  register-file write enable.
REQ-011 SHALL have port rf_addr  output  5  write address.
REQ-012 SHALL have port rf_data  output  64 [0:63]  write data.
REQ-013 SHALL have port rf_bmask  output  8 [0:7]  byte write mask; bit i covers data bits 8i..8i+7.
REQ-014 SHALL have port fwd_addr  input  5  register whose pending value is queried.
REQ-015 SHALL have port fwd_hit  output  1  query matches a queued full-width entry.
REQ-016 SHALL have port fwd_data  output  64 [0:63]  data of youngest matching entry.
REQ-017 SHALL have port stall  output  1  upstream issue must halt.
REQ-018 SHALL have port ovf_err  output  1  sticky: result dropped because queue was full.

Function
REQ-019 SHALL decode in_ppp to a byte mask: 000 all bytes, 001 bytes 0-3, 010 bytes 4-7, 011 bytes 0,2,4,6, 100 bytes 1,3,5,7, 101-111 no bytes.
REQ-020 SHALL push {in_rD, in_data, mask} on a rising edge when in_v=1, mask nonzero, and the queue is not full or a pop occurs in the same cycle.
REQ-021 SHALL silently discard in_v with mask zero (no push, no error).
REQ-022 SHALL, when in_v=1 with nonzero mask, queue full, and no pop that cycle, drop the result and set ovf_err, which remains 1 until reset.
REQ-023 SHALL drive rf_we = (queue not empty) AND rf_ready combinationally, with rf_addr/rf_data/rf_bmask taken from the head entry; rf_addr/rf_data/rf_bmask SHALL be 0 when empty.
REQ-024 SHALL pop the head on each rising edge where rf_we=1; minimum in_v-to-rf_we latency is one cycle (no same-cycle bypass).
REQ-025 SHALL preserve arrival order; head-to-tail order equals in_v order.
REQ-026 SHALL use wrap-around read/write pointers modulo DEPTH plus a separate occupancy count 0..DEPTH.
REQ-027 SHALL assert stall combinationally when count >= AFULL.
REQ-028 SHALL assert fwd_hit when any valid entry has rD = fwd_addr and mask = all bytes; fwd_data SHALL be the youngest such entry; fwd_data SHALL be 0 when fwd_hit=0.
REQ-029 SHALL ignore partial-mask entries for forwarding, and an older full entry SHALL NOT hit if a younger partial entry to the same rD exists (fwd_hit=0).
REQ-030 SHALL, on simultaneous push and pop, leave count unchanged.

Reset
REQ-031 SHALL on reset assertion immediately clear count, pointers and ovf_err, forcing rf_we=0, stall=0, fwd_hit=0, rf_addr/rf_data/rf_bmask/fwd_data=0.
REQ-032 SHALL discard all queued entries on reset mid-operation; entry payload storage needs no reset.
REQ-033 SHALL ignore in_v on the first rising edge while reset is high.

Structure
REQ-034 SHALL place PPP encodings, the 8-bit full-mask constant and the DEPTH default in the shared processor package.
REQ-035 SHALL implement the PPP-to-mask decode as combinational sub-module ppp_bmask_dec.

Verification
REQ-036 SHALL test: in_v with in_data=0x0123456789ABCDEF, in_rD=5, in_ppp=000, rf_ready=1 -> next cycle rf_we=1, rf_addr=5, rf_bmask=0xFF, then empty.
REQ-037 SHALL test: rf_ready=0, five pushes (rD 1..5, DEPTH=4) -> stall at count 3, fifth dropped, ovf_err=1; rf_ready=1 -> writes rD 1,2,3,4 in order.
REQ-038 SHALL test: full queue, in_v while rf_ready=1 -> push accepted, count stays 4, ovf_err=0.
REQ-039 SHALL test: push rD=7 ppp=000 data A, then rD=7 ppp=001 data B, fwd_addr=7 -> fwd_hit=0; push rD=7 ppp=000 data C -> fwd_hit=1, fwd_data=C.
REQ-040 SHALL test: in_ppp=011 -> rf_bmask=10101010b; in_ppp=110 -> no push, rf_we stays 0.
REQ-041 SHALL test: reset asserted mid-drain with 3 entries -> rf_we=0 and stall=0 without a clock edge; after release, no residual writes.
